// File: rtl/pcpi_initiator_if.sv
// PCPI coprocessor bus: issue side driven by the initiator, result side by the coprocessor.
interface pcpi_initiator_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/pcpi_initiator.sv
// Issues one pipeline request at a time onto the PCPI bus and returns the coprocessor result.
// Optional illegal-instruction timeout is enabled by defining PCPI_TIMEOUT_EN.
module pcpi_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_insn,
    input  logic [31:0]         req_rs1,
    input  logic [31:0]         req_rs2,
    input  logic [4:0]          req_rd_idx,
    pcpi_initiator_if.master    pcpi,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_data,
    output logic [4:0]          rsp_rd_idx,
    output logic                rsp_wr,
    output logic                rsp_illegal,
    output logic [7:0]          rsp_cycles
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state, next_state;
    logic               accept_c;
    logic               timeout_c;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   issue_inc_c;
    logic               req_ready_d, pcpi_valid_d, rsp_valid_d;

    assign accept_c    = (state == IDLE) && req_valid && req_ready;
    assign issue_inc_c = (issue_cnt == '1) ? issue_cnt : issue_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; a coincident pcpi_ready takes the legal path over timeout
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_c) next_state = ISSUE;
            ISSUE:   if (pcpi.pcpi_ready || timeout_c) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake flags are decoded from next_state so the registered copies track state
    always_comb begin
        req_ready_d  = 1'b0;
        pcpi_valid_d = 1'b0;
        rsp_valid_d  = 1'b0;
        case (next_state)
            IDLE:    req_ready_d  = 1'b1;
            ISSUE:   pcpi_valid_d = 1'b1;
            RESP:    rsp_valid_d  = 1'b1;
            default: req_ready_d  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready       <= 1'b0;
            pcpi.pcpi_valid <= 1'b0;
            rsp_valid       <= 1'b0;
            pcpi.pcpi_insn  <= '0;
            pcpi.pcpi_rs1   <= '0;
            pcpi.pcpi_rs2   <= '0;
            rsp_rd_idx      <= '0;
            rsp_data        <= '0;
            rsp_wr          <= 1'b0;
            rsp_illegal     <= 1'b0;
            rsp_cycles      <= '0;
            issue_cnt       <= '0;
        end else begin
            req_ready       <= req_ready_d;
            pcpi.pcpi_valid <= pcpi_valid_d;
            rsp_valid       <= rsp_valid_d;
            if (accept_c) begin
                pcpi.pcpi_insn <= req_insn;
                pcpi.pcpi_rs1  <= req_rs1;
                pcpi.pcpi_rs2  <= req_rs2;
                rsp_rd_idx     <= req_rd_idx;
                issue_cnt      <= '0;
            end
            if (state == ISSUE) begin
                issue_cnt <= issue_inc_c;
                if (pcpi.pcpi_ready) begin
                    rsp_data    <= pcpi.pcpi_rd;
                    rsp_wr      <= pcpi.pcpi_wr;
                    rsp_illegal <= 1'b0;
                    rsp_cycles  <= issue_inc_c;
                end else if (timeout_c) begin
                    rsp_data    <= '0;
                    rsp_wr      <= 1'b0;
                    rsp_illegal <= 1'b1;
                    rsp_cycles  <= issue_inc_c;
                end
            end
        end
    end

`ifdef PCPI_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0]   to_cnt;
    logic [CNT_W-1:0]   to_inc_c;
    logic               wait_seen;

    assign to_inc_c  = to_cnt + CNT_W'(1);
    assign timeout_c = (state == ISSUE) && !wait_seen && !pcpi.pcpi_wait && (to_inc_c == TO_LIMIT);

    // Counter stops for the rest of the transaction once the coprocessor claims it via pcpi_wait
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt    <= '0;
            wait_seen <= 1'b0;
        end else if (accept_c) begin
            to_cnt    <= '0;
            wait_seen <= 1'b0;
        end else if (state == ISSUE) begin
            if (pcpi.pcpi_wait)  wait_seen <= 1'b1;
            else if (!wait_seen) to_cnt    <= to_inc_c;
        end
    end
`else
    logic unused_cfg;

    assign timeout_c  = 1'b0;
    assign unused_cfg = ^{pcpi.pcpi_wait, CNT_W'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_pcpi_initiator.sv
// Directed table-driven bench for pcpi_initiator with a behavioural divider/remainder coprocessor.
module tb_pcpi_initiator;
    localparam int unsigned TO = 16;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        int          lat;       // pcpi_valid cycle on which ready is driven (0 = never)
        int          wait_n;    // pcpi_wait driven for this many leading cycles
        int          bp;        // rsp_ready held low this many cycles
        logic        wr;
        logic [31:0] exp_data;
        logic        exp_wr;
        logic        exp_ill;
        int          exp_vcyc;
        logic        chk_cyc;
        logic [7:0]  exp_cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_insn, req_rs1, req_rs2;
    logic [4:0]  req_rd_idx;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd_idx;
    logic        rsp_wr, rsp_illegal;
    logic [7:0]  rsp_cycles;

    int n_pass  = 0;
    int n_total = 0;

    pcpi_initiator_if bus();

    pcpi_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_insn   (req_insn),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd_idx (req_rd_idx),
        .pcpi       (bus),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rd_idx (rsp_rd_idx),
        .rsp_wr     (rsp_wr),
        .rsp_illegal(rsp_illegal),
        .rsp_cycles (rsp_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [4:0] rd, input int lat, input int wait_n, input int bp,
                                input logic wr, input logic [31:0] exp_data, input logic exp_wr,
                                input logic exp_ill, input int exp_vcyc, input logic chk_cyc,
                                input logic [7:0] exp_cyc);
        vec_t v;
        v.insn = insn; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.lat = lat; v.wait_n = wait_n; v.bp = bp; v.wr = wr;
        v.exp_data = exp_data; v.exp_wr = exp_wr; v.exp_ill = exp_ill;
        v.exp_vcyc = exp_vcyc; v.chk_cyc = chk_cyc; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    // Coprocessor behaviour: DIVU, REM, otherwise a fixed stub value
    function automatic logic [31:0] coproc(input vec_t v);
        logic signed [31:0] a, b;
        logic [2:0] f3;
        f3 = v.insn[14:12];
        a  = v.rs1;
        b  = v.rs2;
        case (f3)
            3'd5:    return (v.rs2 == 32'd0) ? 32'hFFFF_FFFF : v.rs1 / v.rs2;
            3'd6:    return 32'(a % b);
            default: return 32'hC0DE_0001;
        endcase
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int          k;
        logic        ok;
        logic [31:0] held;
        k = 0;
        while (!req_ready && k < 50) begin
            tick();
            k++;
        end
        check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        req_insn = v.insn; req_rs1 = v.rs1; req_rs2 = v.rs2; req_rd_idx = v.rd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        ok = 1'b1;
        k  = 0;
        while (bus.pcpi_valid && k < 400) begin
            k++;
            ok = ok && (bus.pcpi_insn == v.insn) && (bus.pcpi_rs1 == v.rs1) && (bus.pcpi_rs2 == v.rs2);
            bus.pcpi_wait = (k <= v.wait_n);
            if (k == v.lat) begin
                bus.pcpi_ready = 1'b1;
                bus.pcpi_rd    = coproc(v);
                bus.pcpi_wr    = v.wr;
            end else begin
                bus.pcpi_ready = 1'b0;
                bus.pcpi_rd    = 32'hBAD0_0000 ^ 32'(k);
                bus.pcpi_wr    = ~v.wr;
            end
            tick();
        end
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wait  = 1'b0;
        check({tag, "/valid_cycles"}, 32'(k), 32'(v.exp_vcyc));
        check({tag, "/operands_stable"}, 32'(ok), 32'd1);
        check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "/pcpi_valid_low"}, 32'(bus.pcpi_valid), 32'd0);
        check({tag, "/rsp_data"}, rsp_data, v.exp_data);
        check({tag, "/rsp_wr"}, 32'(rsp_wr), 32'(v.exp_wr));
        check({tag, "/rsp_rd_idx"}, 32'(rsp_rd_idx), 32'(v.rd));
        check({tag, "/rsp_illegal"}, 32'(rsp_illegal), 32'(v.exp_ill));
        if (v.chk_cyc) check({tag, "/rsp_cycles"}, 32'(rsp_cycles), 32'(v.exp_cyc));
        held = rsp_data;
        ok   = 1'b1;
        // Stray pcpi_ready pulses while in RESP must not disturb the held response
        for (int i = 0; i < v.bp; i++) begin
            bus.pcpi_ready = 1'b1;
            bus.pcpi_rd    = 32'h5A5A_0000 ^ 32'(i);
            ok = ok && rsp_valid && (rsp_data == held) && !req_ready && !bus.pcpi_valid;
            tick();
        end
        bus.pcpi_ready = 1'b0;
        ok = ok && rsp_valid && (rsp_data == held) && !req_ready && !bus.pcpi_valid;
        check({tag, "/resp_hold"}, 32'(ok), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "/idle_after"}, 32'({rsp_valid, req_ready, bus.pcpi_valid}), 32'b010);
    endtask

    initial begin
        vec_t vecs[$];
        logic ok;

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_insn = '0; req_rs1 = '0; req_rs2 = '0; req_rd_idx = '0;
        bus.pcpi_wr = 1'b0; bus.pcpi_rd = '0; bus.pcpi_wait = 1'b0; bus.pcpi_ready = 1'b0;

        tick();
        check("reset/req_ready", 32'(req_ready), 32'd0);
        check("reset/pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
        check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset/rsp_data", rsp_data, 32'd0);
        check("reset/rsp_flags", 32'({rsp_wr, rsp_illegal}), 32'd0);
        check("reset/rsp_cycles", 32'(rsp_cycles), 32'd0);
        check("reset/pcpi_insn", bus.pcpi_insn, 32'd0);
        reset = 1'b0;
        tick();
        check("post_reset/req_ready", 32'(req_ready), 32'd1);

        // pcpi_ready in IDLE is ignored
        bus.pcpi_ready = 1'b1; bus.pcpi_rd = 32'h1234_5678; bus.pcpi_wr = 1'b1;
        tick();
        tick();
        bus.pcpi_ready = 1'b0; bus.pcpi_wr = 1'b0;
        check("idle_ready/rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_ready/req_ready", 32'(req_ready), 32'd1);
        check("idle_ready/rsp_data", rsp_data, 32'd0);

        //             insn          rs1           rs2           rd     lat wn  bp  wr    data          ewr   ill   vcyc chk   cyc
        vecs.push_back(mk(32'h0200_5033, 32'd100,      32'd7,  5'd5,  3,  0,  0, 1'b1, 32'd14,       1'b1, 1'b0, 3,   1'b1, 8'd3));
        vecs.push_back(mk(32'h0200_6033, 32'hFFFF_FFF9, 32'd2, 5'd10, 1,  0,  2, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1,   1'b1, 8'd1));
        vecs.push_back(mk(32'h0200_5033, 32'd9,        32'd3,  5'd31, 5,  5, 10, 1'b1, 32'd3,        1'b1, 1'b0, 5,   1'b1, 8'd5));
        vecs.push_back(mk(32'h0000_000B, 32'd1,        32'd2,  5'd0,  2,  0,  1, 1'b0, 32'hC0DE_0001, 1'b0, 1'b0, 2,   1'b1, 8'd2));
        vecs.push_back(mk(32'h0200_5033, 32'd1000,     32'd10, 5'd7,  20, 20, 0, 1'b1, 32'd100,      1'b1, 1'b0, 20,  1'b1, 8'd20));
        vecs.push_back(mk(32'h0200_5033, 32'hFFFF_FFFF, 32'd1, 5'd3,  300, 300, 0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 300, 1'b1, 8'd255));
`ifdef PCPI_TIMEOUT_EN
        vecs.push_back(mk(32'h0000_0013, 32'd0,        32'd0,  5'd1,  0,  0,  0, 1'b0, 32'd0,        1'b0, 1'b1, 16,  1'b0, 8'd0));
        vecs.push_back(mk(32'h0000_000B, 32'd4,        32'd4,  5'd2,  16, 0,  0, 1'b1, 32'hC0DE_0001, 1'b1, 1'b0, 16,  1'b1, 8'd16));
        vecs.push_back(mk(32'h0200_5033, 32'd50,       32'd5,  5'd9,  30, 1,  0, 1'b1, 32'd10,       1'b1, 1'b0, 30,  1'b1, 8'd30));
`else
        vecs.push_back(mk(32'h0200_5033, 32'd7,        32'd2,  5'd9,  40, 0,  0, 1'b1, 32'd3,        1'b1, 1'b0, 40,  1'b1, 8'd40));
`endif

        foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset five cycles into a DIVU abandons it
        req_insn = 32'h0200_5033; req_rs1 = 32'd100; req_rs2 = 32'd7; req_rd_idx = 5'd5;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("mid_reset/pcpi_valid_rise", 32'(bus.pcpi_valid), 32'd1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("mid_reset/pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
        check("mid_reset/rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_reset/req_ready", 32'(req_ready), 32'd0);
        check("mid_reset/pcpi_insn", bus.pcpi_insn, 32'd0);
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            ok = ok && !rsp_valid && !bus.pcpi_valid;
        end
        check("mid_reset/no_response", 32'(ok), 32'd1);
        run_txn(mk(32'h0200_5033, 32'd9, 32'd3, 5'd4, 2, 0, 0, 1'b1, 32'd3, 1'b1, 1'b0, 2, 1'b1, 8'd2), "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
